// File: rtl/alu_share_arb.sv
// Arbitrates one external combinational ALU between two requesters (round-robin or fixed priority).
// Accepted ops land in a per-port response slot one cycle later; a full, undrained slot stalls only its own port.
module alu_share_arb #(
  parameter int WIDTH         = 32,
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_f,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_zero,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_f,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_zero
);

  logic last_grant;
  logic slot_free0, slot_free1;
  logic elig0, elig1;
  logic grant0, grant1;

  // A slot counts as free when it is empty or being drained on this edge.
  // Requests are never accepted while reset is asserted.
  assign slot_free0 = !rsp0_valid || rsp0_ready;
  assign slot_free1 = !rsp1_valid || rsp1_ready;
  assign elig0      = req0_valid && slot_free0 && !rst;
  assign elig1      = req1_valid && slot_free1 && !rst;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      if (PRIORITY_MODE) begin
        grant0 = 1'b1;
      end else if (last_grant) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = '0;
    if (grant0) begin
      alu_a = req0_a;
      alu_b = req0_b;
      alu_f = req0_f;
    end else if (grant1) begin
      alu_a = req1_a;
      alu_b = req1_b;
      alu_f = req1_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp0_s     <= '0;
      rsp0_zero  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_s     <= '0;
      rsp1_zero  <= 1'b0;
    end else begin
      // Loading a new result takes precedence over draining the old one.
      if (grant0) begin
        rsp0_valid <= 1'b1;
        rsp0_s     <= alu_s;
        rsp0_zero  <= alu_zero;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end

      if (grant1) begin
        rsp1_valid <= 1'b1;
        rsp1_s     <= alu_s;
        rsp1_zero  <= alu_zero;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end

      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized and directed bench for alu_share_arb: an external ALU model feeds the DUT, and a
// queue scoreboard plus an arbitration reference model check every cycle.
module tb_alu_share_arb;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] s;
    logic         z;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic [W-1:0] req0_a, req0_b, rsp0_s;
  logic [2:0]   req0_f;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0] req1_a, req1_b, rsp1_s;
  logic [2:0]   req1_f;
  logic [W-1:0] alu_a, alu_b, alu_s;
  logic [2:0]   alu_f;
  logic         alu_zero;

  logic         fp_req0_valid, fp_req0_ready, fp_rsp0_valid, fp_rsp0_ready, fp_rsp0_zero;
  logic [W-1:0] fp_req0_a, fp_req0_b, fp_rsp0_s;
  logic [2:0]   fp_req0_f;
  logic         fp_req1_valid, fp_req1_ready, fp_rsp1_valid, fp_rsp1_ready, fp_rsp1_zero;
  logic [W-1:0] fp_req1_a, fp_req1_b, fp_rsp1_s;
  logic [2:0]   fp_req1_f;
  logic [W-1:0] fp_alu_a, fp_alu_b, fp_alu_s;
  logic [2:0]   fp_alu_f;
  logic         fp_alu_zero;

  int errors = 0;
  int checks = 0;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_s       = alu_ref(alu_a, alu_b, alu_f);
  assign alu_zero    = (alu_s == '0);
  assign fp_alu_s    = alu_ref(fp_alu_a, fp_alu_b, fp_alu_f);
  assign fp_alu_zero = (fp_alu_s == '0);

  alu_share_arb #(.WIDTH(W), .PRIORITY_MODE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_f(req0_f), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s),
    .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_f(req1_f), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s),
    .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s), .alu_zero(alu_zero)
  );

  alu_share_arb #(.WIDTH(W), .PRIORITY_MODE(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_a(fp_req0_a),
    .req0_b(fp_req0_b), .req0_f(fp_req0_f), .rsp0_valid(fp_rsp0_valid),
    .rsp0_ready(fp_rsp0_ready), .rsp0_s(fp_rsp0_s), .rsp0_zero(fp_rsp0_zero),
    .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_a(fp_req1_a),
    .req1_b(fp_req1_b), .req1_f(fp_req1_f), .rsp1_valid(fp_rsp1_valid),
    .rsp1_ready(fp_rsp1_ready), .rsp1_s(fp_rsp1_s), .rsp1_zero(fp_rsp1_zero),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_f(fp_alu_f), .alu_s(fp_alu_s),
    .alu_zero(fp_alu_zero)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot occupancy, round-robin pointer and expected-result queues.
  rsp_t         q0[$];
  rsp_t         q1[$];
  logic         m_full0 = 1'b0;
  logic         m_full1 = 1'b0;
  logic         m_last  = 1'b1;
  logic         e0, e1, g0, g1;
  logic [W-1:0] ea, eb;
  logic [2:0]   ef;
  rsp_t         r;

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_full0 = 1'b0;
      m_full1 = 1'b0;
      m_last  = 1'b1;
    end else begin
      e0 = req0_valid && (!m_full0 || rsp0_ready);
      e1 = req1_valid && (!m_full1 || rsp1_ready);
      if (e0 && e1) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = e0;
        g1 = e1;
      end
      chk("req0_ready", W'(req0_ready), W'(g0));
      chk("req1_ready", W'(req1_ready), W'(g1));
      chk("rsp0_valid", W'(rsp0_valid), W'(m_full0));
      chk("rsp1_valid", W'(rsp1_valid), W'(m_full1));

      ea = g0 ? req0_a : (g1 ? req1_a : '0);
      eb = g0 ? req0_b : (g1 ? req1_b : '0);
      ef = g0 ? req0_f : (g1 ? req1_f : 3'b000);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_f", W'(alu_f), W'(ef));

      if (m_full0) begin
        if (q0.size() == 0) begin
          chk("rsp0_queue_nonempty", W'(0), W'(1));
        end else begin
          r = q0[0];
          chk("rsp0_s", rsp0_s, r.s);
          chk("rsp0_zero", W'(rsp0_zero), W'(r.z));
          if (rsp0_ready) void'(q0.pop_front());
        end
      end
      if (m_full1) begin
        if (q1.size() == 0) begin
          chk("rsp1_queue_nonempty", W'(0), W'(1));
        end else begin
          r = q1[0];
          chk("rsp1_s", rsp1_s, r.s);
          chk("rsp1_zero", W'(rsp1_zero), W'(r.z));
          if (rsp1_ready) void'(q1.pop_front());
        end
      end

      if (g0) begin
        r.s = alu_ref(req0_a, req0_b, req0_f);
        r.z = (r.s == '0);
        q0.push_back(r);
      end
      if (g1) begin
        r.s = alu_ref(req1_a, req1_b, req1_f);
        r.z = (r.s == '0);
        q1.push_back(r);
      end
      m_full0 = g0 || (m_full0 && !rsp0_ready);
      m_full1 = g1 || (m_full1 && !rsp1_ready);
      if (g0) m_last = 1'b0;
      else if (g1) m_last = 1'b1;
    end
  end

  logic pend0 = 1'b0;
  logic pend1 = 1'b0;

  task automatic cyc();
    @(negedge clk);
    pend0 = req0_valid && !req0_ready;
    pend1 = req1_valid && !req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] f);
    req0_valid = v; req0_a = a; req0_b = b; req0_f = f;
  endtask

  task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] f);
    req1_valid = v; req1_a = a; req1_b = b; req1_f = f;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 15));
      1:       return W'($urandom);
      2:       return '0;
      default: return 32'hFFFF_FFF0 + W'($urandom_range(0, 15));
    endcase
  endfunction

  logic [2:0] code_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

  initial begin
    set0(1'b0, '0, '0, 3'b000);
    set1(1'b0, '0, '0, 3'b000);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    fp_req0_valid = 1'b0; fp_req0_a = '0; fp_req0_b = '0; fp_req0_f = 3'b000;
    fp_req1_valid = 1'b0; fp_req1_a = '0; fp_req1_b = '0; fp_req1_f = 3'b000;
    fp_rsp0_ready = 1'b1; fp_rsp1_ready = 1'b1;

    #1 rst = 1'b1;
    #1;
    chk("reset_rsp0_valid", W'(rsp0_valid), W'(0));
    chk("reset_rsp0_s", rsp0_s, '0);
    chk("reset_rsp0_zero", W'(rsp0_zero), W'(0));
    chk("reset_rsp1_valid", W'(rsp1_valid), W'(0));
    chk("reset_rsp1_s", rsp1_s, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Round-robin tie straight after reset: grants 0,1,0,1.
    set0(1'b1, 32'd5, 32'd3, 3'b010);
    set1(1'b1, 32'd7, 32'd7, 3'b110);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_tie_grant0", W'(req0_ready), W'(i % 2 == 0));
      chk("rr_tie_grant1", W'(req1_ready), W'(i % 2 == 1));
      cyc();
      if (i == 1) begin
        chk("rr_rsp1_s", rsp1_s, '0);
        chk("rr_rsp1_zero", W'(rsp1_zero), W'(1));
      end
    end
    set0(1'b0, '0, '0, 3'b000);
    set1(1'b0, '0, '0, 3'b000);
    cyc();

    // Single op on port 0.
    set0(1'b1, 32'd5, 32'd3, 3'b010);
    #1 chk("single_req0_ready", W'(req0_ready), W'(1));
    cyc();
    chk("single_rsp0_valid", W'(rsp0_valid), W'(1));
    chk("single_rsp0_s", rsp0_s, 32'd8);
    chk("single_rsp0_zero", W'(rsp0_zero), W'(0));
    set0(1'b0, '0, '0, 3'b000);
    cyc();

    // Backpressure on port 0 while port 1 uses the ALU.
    rsp0_ready = 1'b0;
    set0(1'b1, 32'd5, 32'd3, 3'b010);
    cyc();
    set0(1'b1, 32'd1, 32'd1, 3'b010);
    set1(1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b001);
    #1;
    chk("bp_req0_ready", W'(req0_ready), W'(0));
    chk("bp_req1_ready", W'(req1_ready), W'(1));
    cyc();
    chk("bp_rsp0_s_held", rsp0_s, 32'd8);
    chk("bp_rsp1_s", rsp1_s, 32'h0000_00FF);
    set0(1'b0, '0, '0, 3'b000);
    set1(1'b0, '0, '0, 3'b000);
    cyc();
    chk("bp_rsp0_still_valid", W'(rsp0_valid), W'(1));

    // Drain and reload on the same edge.
    rsp0_ready = 1'b1;
    set0(1'b1, 32'd2, 32'd9, 3'b111);
    #1 chk("reload_req0_ready", W'(req0_ready), W'(1));
    cyc();
    chk("reload_rsp0_valid", W'(rsp0_valid), W'(1));
    chk("reload_rsp0_s", rsp0_s, 32'd1);
    set0(1'b0, '0, '0, 3'b000);
    cyc();

    // Reset while port 1 holds a result.
    rsp1_ready = 1'b0;
    set1(1'b1, 32'd3, 32'd6, 3'b010);
    cyc();
    set1(1'b0, '0, '0, 3'b000);
    chk("mid_rsp1_valid_before", W'(rsp1_valid), W'(1));
    #1 rst = 1'b1;
    #1;
    chk("mid_rsp1_valid", W'(rsp1_valid), W'(0));
    chk("mid_rsp1_s", rsp1_s, '0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set0(1'b1, 32'd4, 32'd4, 3'b000);
    set1(1'b1, 32'd6, 32'd2, 3'b110);
    #1;
    chk("in_reset_req0_ready", W'(req0_ready), W'(0));
    chk("in_reset_req1_ready", W'(req1_ready), W'(0));
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("post_reset_tie_req0", W'(req0_ready), W'(1));
    chk("post_reset_tie_req1", W'(req1_ready), W'(0));
    cyc();
    #1 chk("post_reset_second_req1", W'(req1_ready), W'(1));
    cyc();
    set0(1'b0, '0, '0, 3'b000);
    set1(1'b0, '0, '0, 3'b000);
    cyc();

    // Randomized traffic; a pending request keeps its operands until accepted.
    for (int n = 0; n < 500; n++) begin
      if (!pend0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = rnd_op();
        req0_b = ($urandom_range(0, 4) == 0) ? req0_a : rnd_op();
        req0_f = code_tab[$urandom_range(0, 7)];
      end
      if (!pend1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = rnd_op();
        req1_b = ($urandom_range(0, 4) == 0) ? req1_a : rnd_op();
        req1_f = code_tab[$urandom_range(0, 7)];
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    set0(1'b0, '0, '0, 3'b000);
    set1(1'b0, '0, '0, 3'b000);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cyc();
    cyc();

    // Fixed-priority instance: port 0 wins every tie.
    fp_req1_valid = 1'b1; fp_req1_a = 32'd7; fp_req1_b = 32'd1; fp_req1_f = 3'b110;
    for (int i = 0; i < 4; i++) begin
      fp_req0_valid = 1'b1; fp_req0_a = W'(i); fp_req0_b = 32'd1; fp_req0_f = 3'b010;
      #1;
      chk("fp_req0_ready", W'(fp_req0_ready), W'(1));
      chk("fp_req1_ready", W'(fp_req1_ready), W'(0));
      cyc();
      chk("fp_rsp0_valid", W'(fp_rsp0_valid), W'(1));
      chk("fp_rsp0_s", fp_rsp0_s, W'(i + 1));
    end
    fp_req0_valid = 1'b0;
    #1 chk("fp_req1_alone_ready", W'(fp_req1_ready), W'(1));
    cyc();
    fp_req1_valid = 1'b0;
    chk("fp_rsp1_valid", W'(fp_rsp1_valid), W'(1));
    chk("fp_rsp1_s", fp_rsp1_s, 32'd6);
    chk("fp_rsp1_zero", W'(fp_rsp1_zero), W'(0));
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
